dmi_arb_buf: RTL and testbench
==============================

// Module: dmi_arb_buf
// PURPOSE
//  Single-clock N-channel DMI request arbiter with per-channel request buffering and in-order response routing.
//  Sits in the core clock domain between several DMI masters (CDC outputs, test port, SBA bridge) and the one DM slave port.
//  Caps in-flight requests at MaxOutstanding; a tag FIFO returns each response to the channel that issued it.
// PARAMETERS
//  NrChannels      2  number of DMI master channels (>=1)
//  ReqDepth        4  entries per channel request FIFO (>=1)
//  MaxOutstanding  2  max requests issued without response (>=1); also the tag FIFO depth
// PORTS
//  clk_i             in   1                          clock
//  rst_ni            in   1                          async reset, active low
//  clear_i           in   1                          sync flush of queued requests
//  req_i             in   NrChannels x dmi_req_t     per-channel request
//  req_valid_i       in   NrChannels                 per-channel request valid
//  req_ready_o       out  NrChannels                 per-channel FIFO not full
//  resp_o            out  dmi_resp_t                 response data, shared by all channels
//  resp_valid_o      out  NrChannels                 response valid, one-hot to owning channel
//  resp_ready_i      in   NrChannels                 per-channel response ready
//  core_dmi_req_o    out  dmi_req_t                  request to DM
//  core_dmi_valid_o  out  1                          request valid
//  core_dmi_ready_i  in   1                          DM accepts request
//  core_dmi_resp_i   in   dmi_resp_t                 response from DM
//  core_dmi_valid_i  in   1                          response valid
//  core_dmi_ready_o  out  1                          response accepted
//  outstanding_o     out  $clog2(MaxOutstanding+1)   in-flight count
// BEHAVIOUR
//  Clock and reset: one clock (clk_i); reset rst_ni is asynchronous, active low.
//  Reset values:
//   - all FIFOs empty; RR pointer = 0; outstanding_o = 0
//   - core_dmi_valid_o = 0; core_dmi_req_o = '0; resp_valid_o = 0; core_dmi_ready_o = 0
//   - req_ready_o = all 1 once reset is released
//  Reset mid-operation drops all queued requests and in-flight tags. Responses arriving afterwards are not accepted (ready = 0).
//  Request push:
//   - req_valid_i[k] & req_ready_o[k] writes FIFO k
//   - FIFO output is registered: earliest core_dmi_valid_o is the cycle after the push
//   - push and pop on a full FIFO in the same cycle is allowed
//  Arbitration (round-robin):
//   - eligible = FIFO non-empty AND outstanding_o < MaxOutstanding
//   - search starts at the RR pointer; pointer moves to granted+1 (mod NrChannels) only on handshake
//   - handshake = core_dmi_valid_o & core_dmi_ready_i
//  Stability: once core_dmi_valid_o is high, grant and core_dmi_req_o stay fixed until handshake. No re-arbitration and no drop of valid.
//  On handshake: pop the granted FIFO and push the granted index into the tag FIFO.
//  Response path (zero latency, combinational):
//   - resp_o = core_dmi_resp_i
//   - resp_valid_o[t] = core_dmi_valid_i & tag_nonempty, where t = tag head
//   - core_dmi_ready_o = tag_nonempty & resp_ready_i[t]
//   - on response handshake, pop the tag FIFO
//  Response with no outstanding tag: core_dmi_ready_o = 0 and a simulation assertion fires.
//  outstanding_o = tag FIFO fill:
//   - +1 on request handshake, -1 on response handshake
//   - both in the same cycle: unchanged
//   - when at MaxOutstanding, core_dmi_valid_o goes low after the current request is accepted
//  clear_i:
//   - next cycle all request FIFOs are empty
//   - exception: a head currently presented (core_dmi_valid_o=1, no handshake) stays until accepted
//   - the tag FIFO is untouched, so in-flight responses are still routed
//   - a push in the same cycle as clear_i is discarded
//  NrChannels=1 degenerates to a buffered pass-through; the RR pointer is constant 0.
// STRUCTURE
//  Types: dm::dmi_req_t and dm::dmi_resp_t come from the shared dm package; no new package types.
//   - add dm::DmiArbReqDepth=4 and dm::DmiArbMaxOutstanding=2 as shared defaults
//  Sub-module dmi_fifo #(type T, Depth): registered sync FIFO with full/empty/flush.
//   - instantiated NrChannels times for requests and once for tags (T = logic [$clog2(NrChannels)-1:0], min width 1)
//  Top level holds the RR pointer, grant-lock register and response steering.
// TESTING
//  1. Assert rst_ni mid-burst -> same edge: core_dmi_valid_o=0, resp_valid_o=0, outstanding_o=0; after release req_ready_o=2'b11.
//  2. Same-cycle push ch0 {addr 0x10, read} and ch1 {addr 0x11, write, 0xDEADBEEF}, ready=1 -> DM sees ch0 then ch1 on consecutive cycles;
//     responses 0x1234 then 0x5678 -> resp_valid_o=01 then 10.
//  3. core_dmi_ready_i=0 for 5 cycles while ch1 keeps pushing -> core_dmi_req_o stable at ch0 head, grant unchanged, then ch1 served.
//  4. MaxOutstanding=2, three requests, no responses -> third held, core_dmi_valid_o=0, outstanding_o=2;
//     one response -> third issued next cycle.
//  5. Request handshake and response handshake in the same cycle -> outstanding_o unchanged, tag FIFO pushes and pops correctly.
//  6. ReqDepth=4: 4 pushes on ch0 -> req_ready_o[0]=0; clear_i with head presented -> only head remains, accepted, ch0 empty.
//     Also resp_ready_i[t]=0 -> core_dmi_ready_o=0.

Source files
------------

// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared DMI request/response types and arbiter defaults
package dm;

  localparam int unsigned DmiArbReqDepth       = 4;
  localparam int unsigned DmiArbMaxOutstanding = 2;

  typedef enum logic [1:0] {
    DTM_NOP   = 2'h0,
    DTM_READ  = 2'h1,
    DTM_WRITE = 2'h2
  } dtm_op_e;

  typedef struct packed {
    logic [6:0]  addr;
    dtm_op_e     op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

endpackage

// File: rtl/dmi_fifo.sv
// rtl/dmi_fifo.sv - registered synchronous FIFO with flush and keep-head option
module dmi_fifo #(
  parameter type         T     = logic,
  parameter int unsigned Depth = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  input  logic keep_head_i,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  T                mem_q [Depth];
  logic [PtrW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(Depth));
  assign data_o  = mem_q[rptr_q];
  assign do_push = push_i & ~flush_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;

  // Flush with keep_head leaves only the entry at the read pointer.
  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      if (keep_head_i && !empty_o) begin
        cnt_d  = CntW'(1);
        wptr_d = ptr_inc(rptr_q);
      end else begin
        cnt_d  = '0;
        wptr_d = rptr_q;
      end
    end else begin
      if (do_push) wptr_d = ptr_inc(wptr_q);
      if (do_pop)  rptr_d = ptr_inc(rptr_q);
      cnt_d = cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/dmi_arb_buf.sv
// rtl/dmi_arb_buf.sv - N-channel DMI round-robin arbiter with request FIFOs and tag-routed responses
module dmi_arb_buf
  import dm::*;
#(
  parameter  int unsigned NrChannels     = 2,
  parameter  int unsigned ReqDepth       = DmiArbReqDepth,
  parameter  int unsigned MaxOutstanding = DmiArbMaxOutstanding,
  localparam int unsigned ChW            = (NrChannels > 1) ? $clog2(NrChannels) : 1,
  localparam int unsigned OutW           = $clog2(MaxOutstanding + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  dmi_req_t              req_i [NrChannels],
  input  logic [NrChannels-1:0] req_valid_i,
  output logic [NrChannels-1:0] req_ready_o,
  output dmi_resp_t             resp_o,
  output logic [NrChannels-1:0] resp_valid_o,
  input  logic [NrChannels-1:0] resp_ready_i,
  output dmi_req_t              core_dmi_req_o,
  output logic                  core_dmi_valid_o,
  input  logic                  core_dmi_ready_i,
  input  dmi_resp_t             core_dmi_resp_i,
  input  logic                  core_dmi_valid_i,
  output logic                  core_dmi_ready_o,
  output logic [OutW-1:0]       outstanding_o
);

  typedef logic [ChW-1:0] ch_t;

  dmi_req_t              head [NrChannels];
  logic [NrChannels-1:0] empty, full, push, pop, keep;
  ch_t                   rr_q, rr_d, lock_ch_q, grant, tag_head;
  logic                  lock_q, arb_valid, req_hs, resp_hs, tag_empty, tag_full;
  logic [OutW-1:0]       out_q, out_d;

  for (genvar k = 0; k < NrChannels; k++) begin : g_req
    assign push[k] = req_valid_i[k] & ~full[k];
    assign pop[k]  = req_hs & (grant == ch_t'(k));
    // A presented-but-unaccepted head must survive a clear.
    assign keep[k] = arb_valid & ~core_dmi_ready_i & (grant == ch_t'(k));

    dmi_fifo #(.T(dmi_req_t), .Depth(ReqDepth)) u_req_fifo (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .flush_i    (clear_i),
      .keep_head_i(keep[k]),
      .push_i     (push[k]),
      .data_i     (req_i[k]),
      .pop_i      (pop[k]),
      .data_o     (head[k]),
      .full_o     (full[k]),
      .empty_o    (empty[k])
    );
  end

  assign req_ready_o = ~full;

  // A locked grant holds the presented request steady until the DM takes it.
  always_comb begin
    int c;
    c         = 0;
    grant     = lock_ch_q;
    arb_valid = lock_q;
    if (!lock_q) begin
      for (int i = 0; i < int'(NrChannels); i++) begin
        c = int'(rr_q) + i;
        if (c >= int'(NrChannels)) c = c - int'(NrChannels);
        if (!arb_valid && !tag_full && !empty[ch_t'(c)]) begin
          arb_valid = 1'b1;
          grant     = ch_t'(c);
        end
      end
    end
  end

  assign req_hs           = arb_valid & core_dmi_ready_i;
  assign core_dmi_valid_o = arb_valid;
  assign core_dmi_req_o   = arb_valid ? head[grant] : '0;

  always_comb begin
    rr_d = rr_q;
    if (req_hs) rr_d = (grant == ch_t'(NrChannels - 1)) ? '0 : grant + 1'b1;
  end

  dmi_fifo #(.T(ch_t), .Depth(MaxOutstanding)) u_tag_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (1'b0),
    .keep_head_i(1'b0),
    .push_i     (req_hs),
    .data_i     (grant),
    .pop_i      (resp_hs),
    .data_o     (tag_head),
    .full_o     (tag_full),
    .empty_o    (tag_empty)
  );

  assign resp_o           = core_dmi_resp_i;
  assign core_dmi_ready_o = ~tag_empty & resp_ready_i[tag_head];
  assign resp_hs          = core_dmi_valid_i & core_dmi_ready_o;

  always_comb begin
    resp_valid_o = '0;
    for (int k = 0; k < int'(NrChannels); k++) begin
      resp_valid_o[k] = core_dmi_valid_i & ~tag_empty & (tag_head == ch_t'(k));
    end
  end

  assign out_d         = out_q + OutW'(req_hs) - OutW'(resp_hs);
  assign outstanding_o = out_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q      <= '0;
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
      out_q     <= '0;
    end else begin
      rr_q      <= rr_d;
      lock_q    <= arb_valid & ~core_dmi_ready_i;
      lock_ch_q <= grant;
      out_q     <= out_d;
    end
  end

  a_resp_has_tag: assert property (@(posedge clk_i) disable iff (!rst_ni)
    core_dmi_valid_i |-> !tag_empty);

endmodule

// File: tb/tb_dmi_arb_buf.sv
// tb/tb_dmi_arb_buf.sv - self-checking bench for dmi_arb_buf
module tb_dmi_arb_buf;

  logic          clk_i = 1'b0;
  logic          rst_ni, clear_i;
  dm::dmi_req_t  req_i [2];
  logic [1:0]    req_valid_i, req_ready_o, resp_valid_o, resp_ready_i;
  dm::dmi_resp_t resp_o, core_dmi_resp_i;
  dm::dmi_req_t  core_dmi_req_o;
  logic          core_dmi_valid_o, core_dmi_ready_i, core_dmi_valid_i, core_dmi_ready_o;
  logic [1:0]    outstanding_o;

  int checks   = 0;
  int failures = 0;

  dm::dmi_req_t mq [2][$];
  int           tagq [$];
  dm::dmi_req_t zero_req;

  always #5 clk_i = ~clk_i;

  dmi_arb_buf #(.NrChannels(2), .ReqDepth(4), .MaxOutstanding(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .req_i(req_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .resp_o(resp_o), .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .core_dmi_req_o(core_dmi_req_o), .core_dmi_valid_o(core_dmi_valid_o),
    .core_dmi_ready_i(core_dmi_ready_i), .core_dmi_resp_i(core_dmi_resp_i),
    .core_dmi_valid_i(core_dmi_valid_i), .core_dmi_ready_o(core_dmi_ready_o),
    .outstanding_o(outstanding_o)
  );

  function automatic dm::dmi_req_t mk_req(input logic [6:0] a, input dm::dtm_op_e op, input logic [31:0] d);
    dm::dmi_req_t r;
    r.addr = a; r.op = op; r.data = d;
    return r;
  endfunction

  function automatic dm::dmi_req_t rand_req();
    return mk_req(7'($urandom), ($urandom_range(0, 1) == 1) ? dm::DTM_READ : dm::DTM_WRITE, $urandom);
  endfunction

  task automatic idle();
    clear_i = 0; req_valid_i = 2'b00; core_dmi_ready_i = 0; core_dmi_valid_i = 0;
    resp_ready_i = 2'b00; core_dmi_resp_i = '0; req_i[0] = '0; req_i[1] = '0;
  endtask

  // Inputs are driven 2 time units after the rising edge and checked 1 unit later.
  task automatic next();
    @(posedge clk_i); #2;
  endtask

  task automatic apply_reset();
    rst_ni = 0; idle();
    repeat (2) @(posedge clk_i);
    #2 rst_ni = 1;
  endtask

  task automatic test_reset();
    rst_ni = 0; idle();
    repeat (2) @(posedge clk_i);
    #3;
    checks++; if (core_dmi_valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b want 0", core_dmi_valid_o); end
    checks++; if (core_dmi_req_o !== zero_req) begin failures++; $display("FAIL rst_req: got %h want 0", core_dmi_req_o); end
    checks++; if (core_dmi_ready_o !== 1'b0) begin failures++; $display("FAIL rst_core_ready: got %b want 0", core_dmi_ready_o); end
    checks++; if (outstanding_o !== 2'd0) begin failures++; $display("FAIL rst_outstanding: got %0d want 0", outstanding_o); end
    rst_ni = 1;
    next();
    req_i[0] = rand_req(); req_i[1] = rand_req(); req_valid_i = 2'b11;
    #1;
    checks++; if (req_ready_o !== 2'b11) begin failures++; $display("FAIL rst_req_ready: got %b want 11", req_ready_o); end
    next();
    req_valid_i = 2'b00; core_dmi_ready_i = 1;
    next();
    core_dmi_ready_i = 0; core_dmi_valid_i = 1; core_dmi_resp_i = '{data: 32'hCAFE, resp: 2'b00};
    #1;
    checks++; if (core_dmi_valid_o !== 1'b1 || outstanding_o !== 2'd1) begin failures++; $display("FAIL midburst_pre: got valid=%b out=%0d want valid=1 out=1", core_dmi_valid_o, outstanding_o); end
    rst_ni = 0;
    #1;
    checks++; if (core_dmi_valid_o !== 1'b0) begin failures++; $display("FAIL midrst_valid: got %b want 0", core_dmi_valid_o); end
    checks++; if (resp_valid_o !== 2'b00) begin failures++; $display("FAIL midrst_resp_valid: got %b want 00", resp_valid_o); end
    checks++; if (outstanding_o !== 2'd0) begin failures++; $display("FAIL midrst_outstanding: got %0d want 0", outstanding_o); end
    checks++; if (core_dmi_ready_o !== 1'b0) begin failures++; $display("FAIL midrst_core_ready: got %b want 0", core_dmi_ready_o); end
    idle();
    next();
    rst_ni = 1;
    next(); #1;
    checks++; if (req_ready_o !== 2'b11 || core_dmi_valid_o !== 1'b0) begin failures++; $display("FAIL post_rst: got ready=%b valid=%b want ready=11 valid=0", req_ready_o, core_dmi_valid_o); end
  endtask

  task automatic test_two_channel();
    dm::dmi_req_t a, b;
    a = mk_req(7'h10, dm::DTM_READ, 32'h0);
    b = mk_req(7'h11, dm::DTM_WRITE, 32'hDEADBEEF);
    apply_reset();
    req_i[0] = a; req_i[1] = b; req_valid_i = 2'b11; core_dmi_ready_i = 1;
    #1;
    checks++; if (core_dmi_valid_o !== 1'b0) begin failures++; $display("FAIL two_latency: got valid=%b want 0", core_dmi_valid_o); end
    next(); req_valid_i = 2'b00; #1;
    checks++; if (core_dmi_valid_o !== 1'b1 || core_dmi_req_o !== a) begin failures++; $display("FAIL two_first: got %b/%h want 1/%h", core_dmi_valid_o, core_dmi_req_o, a); end
    next(); #1;
    checks++; if (core_dmi_valid_o !== 1'b1 || core_dmi_req_o !== b) begin failures++; $display("FAIL two_second: got %b/%h want 1/%h", core_dmi_valid_o, core_dmi_req_o, b); end
    next();
    core_dmi_valid_i = 1; resp_ready_i = 2'b11; core_dmi_resp_i = '{data: 32'h1234, resp: 2'b00};
    #1;
    checks++; if (core_dmi_valid_o !== 1'b0 || outstanding_o !== 2'd2) begin failures++; $display("FAIL two_out: got valid=%b out=%0d want 0/2", core_dmi_valid_o, outstanding_o); end
    checks++; if (resp_valid_o !== 2'b01 || resp_o.data !== 32'h1234) begin failures++; $display("FAIL two_resp0: got %b/%h want 01/1234", resp_valid_o, resp_o.data); end
    next(); core_dmi_resp_i = '{data: 32'h5678, resp: 2'b00}; #1;
    checks++; if (resp_valid_o !== 2'b10 || resp_o.data !== 32'h5678) begin failures++; $display("FAIL two_resp1: got %b/%h want 10/5678", resp_valid_o, resp_o.data); end
    next(); core_dmi_valid_i = 0; #1;
    checks++; if (outstanding_o !== 2'd0) begin failures++; $display("FAIL two_drain: got %0d want 0", outstanding_o); end
  endtask

  task automatic test_stall();
    dm::dmi_req_t a, bq [4];
    apply_reset();
    a = rand_req();
    for (int j = 0; j < 4; j++) bq[j] = rand_req();
    req_i[0] = a; req_valid_i = 2'b01;
    next();
    for (int j = 0; j < 5; j++) begin
      req_i[1] = bq[j % 4]; req_valid_i = (j < 4) ? 2'b10 : 2'b00;
      #1;
      checks++; if (core_dmi_valid_o !== 1'b1 || core_dmi_req_o !== a) begin failures++; $display("FAIL stall_hold%0d: got %b/%h want 1/%h", j, core_dmi_valid_o, core_dmi_req_o, a); end
      if (j == 4) begin
        checks++; if (req_ready_o !== 2'b01) begin failures++; $display("FAIL stall_full: got ready=%b want 01", req_ready_o); end
        core_dmi_ready_i = 1;
      end
      next();
    end
    #1;
    checks++; if (core_dmi_req_o !== bq[0] || outstanding_o !== 2'd1) begin failures++; $display("FAIL stall_ch1: got %h out=%0d want %h out=1", core_dmi_req_o, outstanding_o, bq[0]); end
    next(); #1;
    checks++; if (core_dmi_valid_o !== 1'b0 || outstanding_o !== 2'd2) begin failures++; $display("FAIL stall_cap: got valid=%b out=%0d want 0/2", core_dmi_valid_o, outstanding_o); end
  endtask

  task automatic test_max_out();
    dm::dmi_req_t x [3];
    apply_reset();
    for (int j = 0; j < 3; j++) x[j] = rand_req();
    core_dmi_ready_i = 1;
    for (int j = 0; j < 3; j++) begin
      req_i[0] = x[j]; req_valid_i = 2'b01;
      next();
    end
    req_valid_i = 2'b00;
    #1;
    checks++; if (core_dmi_valid_o !== 1'b0 || outstanding_o !== 2'd2) begin failures++; $display("FAIL max_hold: got valid=%b out=%0d want 0/2", core_dmi_valid_o, outstanding_o); end
    core_dmi_valid_i = 1; resp_ready_i = 2'b01; core_dmi_resp_i = '{data: $urandom, resp: 2'b00};
    #1;
    checks++; if (core_dmi_ready_o !== 1'b1 || resp_valid_o !== 2'b01) begin failures++; $display("FAIL max_resp: got ready=%b rv=%b want 1/01", core_dmi_ready_o, resp_valid_o); end
    next(); core_dmi_valid_i = 0; #1;
    checks++; if (core_dmi_valid_o !== 1'b1 || core_dmi_req_o !== x[2] || outstanding_o !== 2'd1) begin failures++; $display("FAIL max_third: got %b/%h out=%0d want 1/%h out=1", core_dmi_valid_o, core_dmi_req_o, outstanding_o, x[2]); end
    next(); #1;
    checks++; if (outstanding_o !== 2'd2) begin failures++; $display("FAIL max_refill: got %0d want 2", outstanding_o); end
  endtask

  task automatic test_simul();
    dm::dmi_req_t y0, y1;
    apply_reset();
    y0 = rand_req(); y1 = rand_req();
    req_i[0] = y0; req_valid_i = 2'b01; core_dmi_ready_i = 1;
    next();
    req_i[1] = y1; req_valid_i = 2'b10;
    next();
    req_valid_i = 2'b00; core_dmi_valid_i = 1; resp_ready_i = 2'b11; core_dmi_resp_i = '{data: $urandom, resp: 2'b00};
    #1;
    checks++; if (core_dmi_req_o !== y1 || resp_valid_o !== 2'b01 || core_dmi_ready_o !== 1'b1) begin failures++; $display("FAIL simul_pre: got %h rv=%b rdy=%b want %h 01 1", core_dmi_req_o, resp_valid_o, core_dmi_ready_o, y1); end
    next(); #1;
    checks++; if (outstanding_o !== 2'd1 || resp_valid_o !== 2'b10) begin failures++; $display("FAIL simul_both: got out=%0d rv=%b want 1/10", outstanding_o, resp_valid_o); end
    next(); core_dmi_valid_i = 0; #1;
    checks++; if (outstanding_o !== 2'd0) begin failures++; $display("FAIL simul_drain: got %0d want 0", outstanding_o); end
  endtask

  task automatic test_full_clear();
    dm::dmi_req_t z [4];
    apply_reset();
    for (int j = 0; j < 4; j++) begin
      z[j] = rand_req(); req_i[0] = z[j]; req_valid_i = 2'b01;
      next();
    end
    req_valid_i = 2'b00;
    #1;
    checks++; if (req_ready_o !== 2'b10 || core_dmi_req_o !== z[0]) begin failures++; $display("FAIL full_ready: got %b/%h want 10/%h", req_ready_o, core_dmi_req_o, z[0]); end
    clear_i = 1; req_i[1] = rand_req(); req_valid_i = 2'b10;
    next();
    clear_i = 0; req_valid_i = 2'b00;
    #1;
    checks++; if (req_ready_o !== 2'b11 || core_dmi_valid_o !== 1'b1 || core_dmi_req_o !== z[0]) begin failures++; $display("FAIL clear_keep: got %b/%b/%h want 11/1/%h", req_ready_o, core_dmi_valid_o, core_dmi_req_o, z[0]); end
    core_dmi_ready_i = 1;
    next(); #1;
    checks++; if (core_dmi_valid_o !== 1'b0 || outstanding_o !== 2'd1) begin failures++; $display("FAIL clear_empty: got valid=%b out=%0d want 0/1", core_dmi_valid_o, outstanding_o); end
    core_dmi_valid_i = 1; resp_ready_i = 2'b00; core_dmi_resp_i = '{data: $urandom, resp: 2'b00};
    #1;
    checks++; if (core_dmi_ready_o !== 1'b0 || resp_valid_o !== 2'b01) begin failures++; $display("FAIL resp_block: got rdy=%b rv=%b want 0/01", core_dmi_ready_o, resp_valid_o); end
    next(); #1;
    checks++; if (outstanding_o !== 2'd1) begin failures++; $display("FAIL resp_block_out: got %0d want 1", outstanding_o); end
    resp_ready_i = 2'b01;
    #1;
    checks++; if (core_dmi_ready_o !== 1'b1) begin failures++; $display("FAIL resp_unblock: got %b want 1", core_dmi_ready_o); end
    next(); core_dmi_valid_i = 0; #1;
    checks++; if (outstanding_o !== 2'd0) begin failures++; $display("FAIL resp_done: got %0d want 0", outstanding_o); end
  endtask

  // Reference: per-channel queues, an in-flight owner list, a round-robin start index.
  task automatic test_random();
    int rr, lock_ch, grant, c, head_tag;
    bit locked, ev, have_tag, erdy, hs, rhs;
    bit rdy [2];
    logic [1:0] erv;
    apply_reset();
    rr = 0; locked = 0; lock_ch = 0;
    mq[0].delete(); mq[1].delete(); tagq.delete();
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 2; k++) begin
        req_valid_i[k] = 1'($urandom_range(0, 1));
        req_i[k] = rand_req();
      end
      core_dmi_ready_i = ($urandom_range(0, 3) != 0);
      clear_i = ($urandom_range(0, 19) == 0);
      resp_ready_i = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      core_dmi_valid_i = (tagq.size() > 0) && ($urandom_range(0, 1) == 1);
      core_dmi_resp_i = '{data: $urandom, resp: 2'($urandom_range(0, 3))};
      ev = 0; grant = 0;
      if (locked) begin
        ev = 1; grant = lock_ch;
      end else if (tagq.size() < 2) begin
        for (int i = 0; i < 2; i++) begin
          c = (rr + i) % 2;
          if (!ev && mq[c].size() > 0) begin ev = 1; grant = c; end
        end
      end
      have_tag = (tagq.size() > 0);
      head_tag = 0;
      if (have_tag) head_tag = tagq[0];
      erv  = (core_dmi_valid_i && have_tag) ? 2'(1 << head_tag) : 2'b00;
      erdy = have_tag && resp_ready_i[head_tag];
      #1;
      for (int k = 0; k < 2; k++) begin
        rdy[k] = (mq[k].size() < 4);
        checks++; if (req_ready_o[k] !== rdy[k]) begin failures++; $display("FAIL rnd_req_ready[%0d] cyc %0d: got %b want %b", k, n, req_ready_o[k], rdy[k]); end
      end
      checks++; if (core_dmi_valid_o !== ev) begin failures++; $display("FAIL rnd_valid cyc %0d: got %b want %b", n, core_dmi_valid_o, ev); end
      if (ev) begin
        checks++; if (core_dmi_req_o !== mq[grant][0]) begin failures++; $display("FAIL rnd_req cyc %0d: got %h want %h", n, core_dmi_req_o, mq[grant][0]); end
      end
      checks++; if (resp_valid_o !== erv) begin failures++; $display("FAIL rnd_resp_valid cyc %0d: got %b want %b", n, resp_valid_o, erv); end
      checks++; if (core_dmi_ready_o !== erdy) begin failures++; $display("FAIL rnd_core_ready cyc %0d: got %b want %b", n, core_dmi_ready_o, erdy); end
      checks++; if (outstanding_o !== 2'(tagq.size())) begin failures++; $display("FAIL rnd_outstanding cyc %0d: got %0d want %0d", n, outstanding_o, tagq.size()); end
      hs  = ev && core_dmi_ready_i;
      rhs = core_dmi_valid_i && erdy;
      if (rhs) void'(tagq.pop_front());
      if (hs) begin
        void'(mq[grant].pop_front());
        tagq.push_back(grant);
        rr = (grant + 1) % 2;
      end
      if (clear_i) begin
        for (int k = 0; k < 2; k++) begin
          if (ev && !core_dmi_ready_i && k == grant) begin
            while (mq[k].size() > 1) void'(mq[k].pop_back());
          end else begin
            mq[k].delete();
          end
        end
      end else begin
        for (int k = 0; k < 2; k++) if (req_valid_i[k] && rdy[k]) mq[k].push_back(req_i[k]);
      end
      locked  = ev && !core_dmi_ready_i;
      lock_ch = grant;
      next();
    end
    idle();
    next();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    zero_req = '0;
    rst_ni = 0;
    idle();
    test_reset();
    test_two_channel();
    test_stall();
    test_max_out();
    test_simul();
    test_full_clear();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
